// File: rtl/store_buffer_if.sv
// Bundles the store buffer's MEM-stage, flush and data_memory signals.
// master = surrounding core/memory side, slave = the store buffer itself.
interface store_buffer_if;
  logic        st_valid;
  logic        st_ready;
  logic [63:0] st_addr;
  logic [63:0] st_data;
  logic        ld_valid;
  logic [63:0] ld_addr;
  logic [63:0] ld_data;
  logic        flush;
  logic        flush_done;
  logic        empty;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_address;
  logic [63:0] mem_write_data;
  logic [63:0] mem_read_data;

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, flush, mem_read_data,
    input  st_ready, ld_data, flush_done, empty, mem_read, mem_write, mem_address,
           mem_write_data
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, flush, mem_read_data,
    output st_ready, ld_data, flush_done, empty, mem_read, mem_write, mem_address,
           mem_write_data
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO between the MEM stage and data_memory: stores retire in one cycle,
// drain when the memory port is idle, and loads forward from the youngest matching entry.
module store_buffer #(
  parameter int DEPTH    = 4,
  parameter int ADDR_LSB = 3,
  parameter int IDX_W    = 8
) (
  input  logic           clk,
  input  logic           reset,
  store_buffer_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_t;

  state_t           state, state_next;
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count, count_next;
  logic [IDX_W-1:0] idx_mem  [DEPTH];
  logic [63:0]      data_mem [DEPTH];
  logic             push, pop;
  logic             hit;
  logic [63:0]      fwd_data;
  logic [IDX_W-1:0] st_idx, ld_idx;

  assign st_idx = bus.st_addr[ADDR_LSB+IDX_W-1:ADDR_LSB];
  assign ld_idx = bus.ld_addr[ADDR_LSB+IDX_W-1:ADDR_LSB];

  // Derived from registered state only, so a pop never opens st_ready in the same cycle.
  assign bus.st_ready   = (count != FULL) && (state == IDLE);
  assign bus.empty      = (count == '0);
  assign bus.flush_done = (state == DONE);
  assign push           = bus.st_valid && bus.st_ready;
  assign count_next     = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

  // Single memory port: loads win except while flushing, when the core is stalled.
  always_comb begin
    pop                = 1'b0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_address    = '0;
    bus.mem_write_data = '0;
    if ((count != '0) && ((state == FLUSH) || !bus.ld_valid)) begin
      pop                = 1'b1;
      bus.mem_write      = 1'b1;
      bus.mem_address    = 64'(idx_mem[head]) << ADDR_LSB;
      bus.mem_write_data = data_mem[head];
    end else if (bus.ld_valid) begin
      bus.mem_read    = 1'b1;
      bus.mem_address = bus.ld_addr;
    end
  end

  // Scan oldest to youngest so the last match wins; the entry draining now still counts.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((PTR_W+1)'(i) < count) && (idx_mem[head + PTR_W'(i)] == ld_idx)) begin
        hit      = 1'b1;
        fwd_data = data_mem[head + PTR_W'(i)];
      end
    end
    bus.ld_data = !bus.ld_valid ? 64'd0 : (hit ? fwd_data : bus.mem_read_data);
  end

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.flush) state_next = FLUSH;
      FLUSH:   if (count_next == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
    end
  end

  // NOTE: entry storage is not reset; count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      idx_mem[tail]  <= st_idx;
      data_mem[tail] <= bus.st_data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: per-cycle vector table plus hand-written flush and
// reset sequences; a write queue scoreboards every drain against the accepted stores.
module tb_store_buffer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  store_buffer_if bus ();

  store_buffer #(.DEPTH(4), .ADDR_LSB(3), .IDX_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [63:0] mem [256];
  assign bus.mem_read_data = mem[bus.mem_address[10:3]];

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t wq[$];
  wr_t mon_e;

  typedef struct {
    logic        st;
    logic        ld;
    logic [63:0] st_addr;
    logic [63:0] st_data;
    logic [63:0] ld_addr;
    logic [63:0] exp_ld;
    logic        exp_rdy;
    logic        exp_mw;
    logic        exp_mr;
    logic        exp_empty;
  } vec_t;

  vec_t vecs[$];

  localparam logic [63:0] MEM_TAG = 64'hC0DE_0000_0000_0000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] line_addr(input logic [63:0] a);
    return {53'd0, a[10:3], 3'd0};
  endfunction

  function automatic vec_t mk(input logic st, input logic ld, input logic [63:0] sa,
                              input logic [63:0] sd, input logic [63:0] la,
                              input logic [63:0] el, input logic rdy, input logic mw,
                              input logic mr, input logic emp);
    vec_t v;
    v.st = st; v.ld = ld; v.st_addr = sa; v.st_data = sd; v.ld_addr = la; v.exp_ld = el;
    v.exp_rdy = rdy; v.exp_mw = mw; v.exp_mr = mr; v.exp_empty = emp;
    return v;
  endfunction

  // Drive one cycle at the falling edge; an expected-accepted store enters the scoreboard.
  task automatic drive(input logic st, input logic ld, input logic fl, input logic [63:0] sa,
                       input logic [63:0] sd, input logic [63:0] la, input logic acc);
    @(negedge clk);
    bus.st_valid = st;
    bus.st_addr  = sa;
    bus.st_data  = sd;
    bus.ld_valid = ld;
    bus.ld_addr  = la;
    bus.flush    = fl;
    if (st && acc) wq.push_back('{addr: line_addr(sa), data: sd});
    #2;
  endtask

  // Drain monitor: every committed write must match the oldest outstanding store.
  always @(negedge clk) begin
    #3;
    if (reset === 1'b0 && bus.mem_write === 1'b1) begin
      if (wq.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: addr %h data %h with no store pending",
                 bus.mem_address, bus.mem_write_data);
      end else begin
        mon_e = wq.pop_front();
        check("drain_addr", bus.mem_address, mon_e.addr);
        check("drain_data", bus.mem_write_data, mon_e.data);
      end
      mem[bus.mem_address[10:3]] = bus.mem_write_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = MEM_TAG | 64'(i);
    reset        = 1'b1;
    bus.st_valid = 1'b0;
    bus.st_addr  = '0;
    bus.st_data  = '0;
    bus.ld_valid = 1'b0;
    bus.ld_addr  = '0;
    bus.flush    = 1'b0;

    repeat (2) @(negedge clk);
    #2;
    check("rst_st_ready", 64'(bus.st_ready), 64'd1);
    check("rst_empty", 64'(bus.empty), 64'd1);
    check("rst_flush_done", 64'(bus.flush_done), 64'd0);
    check("rst_mem_write", 64'(bus.mem_write), 64'd0);
    check("rst_mem_read", 64'(bus.mem_read), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // st ld st_addr st_data ld_addr exp_ld rdy mw mr empty
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 64'h18, 64'hAAAA_AAAA_AAAA_AAAA, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 64'h40, 64'h11, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 64'h40, 64'h11, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 64'h40, 64'h11, 1, 0, 1, 1));
    vecs.push_back(mk(1, 1, 64'h8, 64'h1, 64'h8, MEM_TAG | 64'h1, 1, 0, 1, 1));
    vecs.push_back(mk(1, 1, 64'h8, 64'h2, 64'h8, 64'h1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 64'h8, 64'h2, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 64'h8, 64'h2, 1, 0, 1, 1));
    vecs.push_back(mk(1, 1, 64'h200, 64'hA0, 64'h100, MEM_TAG | 64'h20, 1, 0, 1, 1));
    vecs.push_back(mk(1, 1, 64'h208, 64'hA1, 64'h100, MEM_TAG | 64'h20, 1, 0, 1, 0));
    vecs.push_back(mk(1, 1, 64'h210, 64'hA2, 64'h100, MEM_TAG | 64'h20, 1, 0, 1, 0));
    vecs.push_back(mk(1, 1, 64'h218, 64'hA3, 64'h100, MEM_TAG | 64'h20, 1, 0, 1, 0));
    vecs.push_back(mk(1, 1, 64'h220, 64'hA4, 64'h100, MEM_TAG | 64'h20, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 64'h228, 64'hA5, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1));

    foreach (vecs[i]) begin
      drive(vecs[i].st, vecs[i].ld, 1'b0, vecs[i].st_addr, vecs[i].st_data,
            vecs[i].ld_addr, vecs[i].exp_rdy);
      check($sformatf("v%0d_st_ready", i), 64'(bus.st_ready), 64'(vecs[i].exp_rdy));
      check($sformatf("v%0d_mem_write", i), 64'(bus.mem_write), 64'(vecs[i].exp_mw));
      check($sformatf("v%0d_mem_read", i), 64'(bus.mem_read), 64'(vecs[i].exp_mr));
      check($sformatf("v%0d_empty", i), 64'(bus.empty), 64'(vecs[i].exp_empty));
      check($sformatf("v%0d_ld_data", i), bus.ld_data, vecs[i].exp_ld);
    end

    // Flush with three entries while a load is held: three back-to-back writes, then done.
    drive(1, 1, 0, 64'h400, 64'hE0, 64'h100, 1);
    drive(1, 1, 0, 64'h408, 64'hE1, 64'h100, 1);
    drive(1, 1, 0, 64'h410, 64'hE2, 64'h100, 1);
    drive(0, 1, 1, 0, 0, 64'h100, 0);
    check("f0_mem_write", 64'(bus.mem_write), 64'd0);
    check("f0_mem_read", 64'(bus.mem_read), 64'd1);
    check("f0_flush_done", 64'(bus.flush_done), 64'd0);
    for (int k = 1; k <= 3; k++) begin
      drive(k == 1, 1, 0, 64'h418, 64'hEE, 64'h100, 0);
      check($sformatf("f%0d_mem_write", k), 64'(bus.mem_write), 64'd1);
      check($sformatf("f%0d_mem_read", k), 64'(bus.mem_read), 64'd0);
      check($sformatf("f%0d_st_ready", k), 64'(bus.st_ready), 64'd0);
      check($sformatf("f%0d_flush_done", k), 64'(bus.flush_done), 64'd0);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    check("f4_flush_done", 64'(bus.flush_done), 64'd1);
    check("f4_mem_write", 64'(bus.mem_write), 64'd0);
    check("f4_empty", 64'(bus.empty), 64'd1);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("f5_flush_done", 64'(bus.flush_done), 64'd0);
    check("f5_st_ready", 64'(bus.st_ready), 64'd1);

    // Flush of an empty buffer; a second pulse while flushing is ignored.
    drive(0, 0, 1, 0, 0, 0, 0);
    check("g0_flush_done", 64'(bus.flush_done), 64'd0);
    drive(0, 0, 1, 0, 0, 0, 0);
    check("g1_flush_done", 64'(bus.flush_done), 64'd0);
    check("g1_st_ready", 64'(bus.st_ready), 64'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("g2_flush_done", 64'(bus.flush_done), 64'd1);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("g3_flush_done", 64'(bus.flush_done), 64'd0);
    check("g3_st_ready", 64'(bus.st_ready), 64'd1);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("g4_flush_done", 64'(bus.flush_done), 64'd0);

    // Reset in the middle of a drain discards the remaining entry.
    drive(1, 1, 0, 64'h300, 64'hD0, 64'h100, 1);
    drive(1, 1, 0, 64'h308, 64'hD1, 64'h100, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("h2_mem_write", 64'(bus.mem_write), 64'd1);
    @(negedge clk);
    reset        = 1'b1;
    bus.st_valid = 1'b0;
    bus.ld_valid = 1'b0;
    bus.flush    = 1'b0;
    #2;
    wq.delete();
    check("h3_empty", 64'(bus.empty), 64'd1);
    check("h3_mem_write", 64'(bus.mem_write), 64'd0);
    check("h3_st_ready", 64'(bus.st_ready), 64'd1);
    check("h3_flush_done", 64'(bus.flush_done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    check("h5_mem_write", 64'(bus.mem_write), 64'd0);
    check("h5_empty", 64'(bus.empty), 64'd1);
    drive(0, 1, 0, 0, 0, 64'h308, 0);
    check("h6_ld_discarded", bus.ld_data, MEM_TAG | 64'h61);
    drive(0, 1, 0, 0, 0, 64'h300, 0);
    check("h7_ld_drained", bus.ld_data, 64'hD0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("queue_drained", 64'(wq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
